// File: rtl/fpu_share_pkg.sv
// Shared types and helpers for the FPU sharing arbiter.
// Structs carry the default-configuration widths; the top builds its own from its parameters.
package fpu_share_pkg;

  localparam int NARGS_DEF    = 3;
  localparam int WOP_DEF      = 6;
  localparam int NDSFLAGS_DEF = 15;
  localparam int NUSFLAGS_DEF = 5;

  typedef struct packed {
    logic [NARGS_DEF-1:0][31:0] operands;
    logic [WOP_DEF-1:0]         op;
    logic [NDSFLAGS_DEF-1:0]    flags;
  } apu_req_t;

  typedef struct packed {
    logic [31:0]             rdata;
    logic [NUSFLAGS_DEF-1:0] rflags;
  } apu_rsp_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_share_id_fifo.sv
// In-order FIFO of issuing-core indices; a push into a full FIFO is legal only alongside a pop.
module fpu_share_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
      if (i_pop)  r_rd <= (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one FPU among NB_CORES cores; the winner is locked until granted
// and responses are routed back in issue order through the ID FIFO.
module fpu_share_arbiter import fpu_share_pkg::*; #(
  parameter int NB_CORES        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NDSFLAGS        = 15,
  parameter int NUSFLAGS        = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_CORES-1:0]                 core_req_i,
  output logic [NB_CORES-1:0]                 core_gnt_o,
  input  logic [NB_CORES-1:0][NARGS-1:0][31:0] core_operands_i,
  input  logic [NB_CORES-1:0][WOP-1:0]        core_op_i,
  input  logic [NB_CORES-1:0][NDSFLAGS-1:0]   core_flags_i,
  output logic [NB_CORES-1:0]                 core_rvalid_o,
  output logic [31:0]                         core_rdata_o,
  output logic [NUSFLAGS-1:0]                 core_rflags_o,
  output logic                                apu_req_o,
  input  logic                                apu_gnt_i,
  output logic [NARGS-1:0][31:0]              apu_operands_o,
  output logic [WOP-1:0]                      apu_op_o,
  output logic [NDSFLAGS-1:0]                 apu_flags_o,
  input  logic                                apu_rvalid_i,
  input  logic [31:0]                         apu_rdata_i,
  input  logic [NUSFLAGS-1:0]                 apu_rflags_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int IW = id_w(NB_CORES);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  typedef struct packed {
    logic [NARGS-1:0][31:0] operands;
    logic [WOP-1:0]         op;
    logic [NDSFLAGS-1:0]    flags;
  } req_t;

  logic [IW-1:0] r_rr, r_lock_id, w_win, w_head;
  logic          r_lock_vld, r_err;
  logic          w_full, w_empty, w_pop, w_req, w_fire, w_drop;
  logic [CW-1:0] w_cnt;
  req_t          w_payload;

  // Round-robin search from r_rr; an active lock overrides the search result.
  always_comb begin
    int  idx;
    logic found;
    found = 1'b0;
    w_win = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NB_CORES) idx = idx - NB_CORES;
      if (!found && core_req_i[idx]) begin
        found = 1'b1;
        w_win = IW'(idx);
      end
    end
    if (r_lock_vld) w_win = r_lock_id;
  end

  // A locked core withdrawing its request drops the issue for one cycle.
  assign w_drop    = r_lock_vld && !core_req_i[r_lock_id];
  assign w_pop     = apu_rvalid_i && !w_empty;
  assign w_req     = (|core_req_i) && !w_drop && (!w_full || w_pop);
  assign w_fire    = w_req && apu_gnt_i;
  assign apu_req_o = w_req;

  always_comb begin
    w_payload = '0;
    if (w_req) w_payload = '{operands: core_operands_i[w_win],
                             op:       core_op_i[w_win],
                             flags:    core_flags_i[w_win]};
  end

  assign apu_operands_o = w_payload.operands;
  assign apu_op_o       = w_payload.op;
  assign apu_flags_o    = w_payload.flags;
  assign core_gnt_o     = w_fire ? (NB_CORES'(1) << w_win) : '0;
  assign core_rvalid_o  = w_pop  ? (NB_CORES'(1) << w_head) : '0;
  assign core_rdata_o   = apu_rdata_i;
  assign core_rflags_o  = apu_rflags_i;
  assign busy_o         = (w_cnt != '0);
  assign err_o          = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= apu_rvalid_i && w_empty;
      if (w_fire) begin
        r_rr       <= (int'(w_win) == NB_CORES-1) ? '0 : w_win + 1'b1;
        r_lock_vld <= 1'b0;
      end else if (w_req) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_win;
      end else if (w_drop) begin
        r_lock_vld <= 1'b0;
      end
    end
  end

  fpu_share_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_fire),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

endmodule
